// File: rtl/hir_arith_pkg.sv
// Shared arithmetic helpers for HIR-generated datapaths: default data
// width and the round-robin index step used by resource arbiters.
package hir_arith_pkg;

  localparam int HIR_DATA_W = 32;

  // Next requester index in round-robin order, wrapping to 0 after num-1.
  // The {valid, idx} tag struct lives in each arbiter, where the index
  // width is known from its own NUM_REQ.
  function automatic int unsigned rr_next(input int unsigned idx,
                                          input int unsigned num);
    return (idx + 32'd1 >= num) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/mult_pipe.sv
// Unsigned multiplier followed by a LATENCY-deep register chain. The product
// is truncated to DATA_W bits. LATENCY = 0 gives a purely combinational
// product, so a consumer can append its own output register.
module mult_pipe #(
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  output logic [DATA_W-1:0] out
);

  logic [DATA_W-1:0] w_prod;
  logic              w_unused_rstn;

  // Data registers carry no reset; validity is tracked by the consumer.
  assign w_unused_rstn = rstn;
  assign w_prod        = in1 * in2;

  if (LATENCY == 0) begin : g_comb
    assign out = w_prod;
  end else begin : g_regs
    logic [DATA_W-1:0] r_stage [LATENCY];

    // Shift the product down the chain one stage per cycle.
    // NOTE: data-only pipeline registers are left unreset on purpose; a
    // separately reset valid bit decides whether their contents are used.
    always_ff @(posedge clk) begin
      r_stage[0] <= w_prod;
      for (int k = 1; k < LATENCY; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
    end

    assign out = r_stage[LATENCY-1];
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier among NUM_REQ
// requesters. One grant per cycle; the product for a grant at cycle t is
// presented with a one-cycle rsp_valid pulse at cycle t+LATENCY.
module mult_share_arbiter
  import hir_arith_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = HIR_DATA_W,
  parameter int LATENCY = 2
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] in1,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] in2,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_W-1:0]              rsp_data,
  output logic                           busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

  logic [IDX_W-1:0]  r_ptr;
  tag_t              r_tag   [LATENCY];
  tag_t              w_tag_d [LATENCY];
  logic [DATA_W-1:0] r_rsp_data;
  logic              w_gnt_any;
  logic [IDX_W-1:0]  w_gnt_idx;
  logic [DATA_W-1:0] w_op_a;
  logic [DATA_W-1:0] w_op_b;
  logic [DATA_W-1:0] w_prod;

  // Grant the first requesting index found searching from r_ptr upward.
  // NOTE: every output of a combinational block gets a default first, so
  // no path through it can leave a value held and infer a latch.
  always_comb begin
    logic [IDX_W-1:0] v_idx;
    gnt       = '0;
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    v_idx     = r_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_gnt_any && req[v_idx]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = v_idx;
      end
      v_idx = IDX_W'(rr_next(32'(v_idx), NUM_REQ));
    end
    if (!rstn) begin
      w_gnt_any = 1'b0;
    end
    gnt[w_gnt_idx] = w_gnt_any;
  end

  // Advance the pointer just past the winner; hold it when nobody is granted.
  // NOTE: clocked state uses non-blocking assignment so every register
  // samples pre-edge values regardless of statement or process order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ptr <= '0;
    end else if (w_gnt_any) begin
      r_ptr <= IDX_W'(rr_next(32'(w_gnt_idx), NUM_REQ));
    end
  end

  assign w_op_a = in1[w_gnt_idx];
  assign w_op_b = in2[w_gnt_idx];

  // The arbiter's output register is the last product stage, so the shared
  // multiplier only provides the first LATENCY-1 stages.
  mult_pipe #(
    .DATA_W  (DATA_W),
    .LATENCY (LATENCY - 1)
  ) u_mult (
    .clk  (clk),
    .rstn (rstn),
    .in1  (w_op_a),
    .in2  (w_op_b),
    .out  (w_prod)
  );

  // Next value of each tag stage: a new tag enters stage 0, the rest shift.
  always_comb begin
    w_tag_d[0] = '{valid: w_gnt_any, idx: w_gnt_idx};
    for (int k = 1; k < LATENCY; k++) begin
      w_tag_d[k] = r_tag[k-1];
    end
  end

  // Tag pipeline; reset discards every in-flight operation.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < LATENCY; k++) begin
        r_tag[k] <= '0;
      end
    end else begin
      for (int k = 0; k < LATENCY; k++) begin
        r_tag[k] <= w_tag_d[k];
      end
    end
  end

  // Capture the product only when a valid tag reaches the output stage.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rsp_data <= '0;
    end else if (w_tag_d[LATENCY-1].valid) begin
      r_rsp_data <= w_prod;
    end
  end

  // Decode the output tag; responses due while reset is low are suppressed.
  always_comb begin
    rsp_valid = '0;
    if (rstn && r_tag[LATENCY-1].valid) begin
      rsp_valid[r_tag[LATENCY-1].idx] = 1'b1;
    end
  end

  // Busy while any tag stage holds a live operation.
  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < LATENCY; k++) begin
      busy = busy | r_tag[k].valid;
    end
  end

  assign rsp_data = r_rsp_data;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with NUM_REQ=4, LATENCY=2.
// Inputs change 1 ns after a rising edge; outputs are checked 1 ns later.
module tb_mult_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int LATENCY = 2;

  logic                           clk;
  logic                           rstn;
  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ-1:0][DATA_W-1:0] in1;
  logic [NUM_REQ-1:0][DATA_W-1:0] in2;
  logic [NUM_REQ-1:0]             gnt;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [DATA_W-1:0]              rsp_data;
  logic                           busy;

  int n_tests;
  int n_fail;

  mult_share_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .LATENCY (LATENCY)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req       (req),
    .in1       (in1),
    .in2       (in2),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req  = '0;
    next_cycle();
    next_cycle();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    req  = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) begin
      in1[i] = 32'd5;
      in2[i] = 32'd5;
    end
    next_cycle();
    next_cycle();
    #1;
    n_tests++;
    if (gnt !== 4'b0000) begin
      n_fail++; $display("FAIL reset_gnt: got %b expected 0000", gnt);
    end
    n_tests++;
    if (rsp_valid !== 4'b0000) begin
      n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid);
    end
    n_tests++;
    if (rsp_data !== 32'd0) begin
      n_fail++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    req  = '0;
    rstn = 1'b1;
    next_cycle();
  endtask

  task automatic test_single();
    do_reset();
    req    = 4'b0001;
    in1[0] = 32'd7;
    in2[0] = 32'd6;
    #1;
    n_tests++;
    if (gnt !== 4'b0001) begin
      n_fail++; $display("FAIL single_gnt: got %b expected 0001", gnt);
    end
    next_cycle();
    req = '0;
    #1;
    n_tests++;
    if (busy !== 1'b1 || rsp_valid !== 4'b0000) begin
      n_fail++; $display("FAIL single_t1: busy %b rsp_valid %b expected busy 1 rsp_valid 0000", busy, rsp_valid);
    end
    next_cycle();
    n_tests++;
    if (rsp_valid !== 4'b0001 || rsp_data !== 32'd42 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_rsp: rsp_valid %b data %0d busy %b expected 0001 42 1", rsp_valid, rsp_data, busy);
    end
    next_cycle();
    n_tests++;
    if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_idle: rsp_valid %b busy %b expected 0000 0", rsp_valid, busy);
    end
  endtask

  task automatic test_all_req();
    logic [DATA_W-1:0] prod [NUM_REQ];
    prod = '{32'd15, 32'd24, 32'd35, 32'd48};
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      in1[i] = 32'(i + 3);
      in2[i] = 32'(i + 5);
    end
    for (int c = 0; c < 10; c++) begin
      logic [NUM_REQ-1:0] exp_gnt;
      logic [NUM_REQ-1:0] exp_rv;
      req     = (c < 8) ? 4'b1111 : 4'b0000;
      exp_gnt = (c < 8) ? 4'(1 << (c % 4)) : 4'b0000;
      exp_rv  = (c >= 2) ? 4'(1 << ((c - 2) % 4)) : 4'b0000;
      #1;
      n_tests++;
      if (gnt !== exp_gnt) begin
        n_fail++; $display("FAIL all_gnt c%0d: got %b expected %b", c, gnt, exp_gnt);
      end
      n_tests++;
      if (rsp_valid !== exp_rv) begin
        n_fail++; $display("FAIL all_rsp_valid c%0d: got %b expected %b", c, rsp_valid, exp_rv);
      end
      if (c >= 2) begin
        n_tests++;
        if (rsp_data !== prod[(c - 2) % 4]) begin
          n_fail++; $display("FAIL all_rsp_data c%0d: got %0d expected %0d", c, rsp_data, prod[(c - 2) % 4]);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_fairness();
    logic [NUM_REQ-1:0] exp_gnt [6];
    exp_gnt = '{4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0001, 4'b0100};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      req = (c < 3) ? 4'b0001 : 4'b0101;
      #1;
      n_tests++;
      if (gnt !== exp_gnt[c]) begin
        n_fail++; $display("FAIL fair_gnt c%0d: got %b expected %b", c, gnt, exp_gnt[c]);
      end
      next_cycle();
    end
    req = '0;
    next_cycle();
    next_cycle();
  endtask

  task automatic test_truncation();
    do_reset();
    in1[1] = 32'hFFFF_FFFF;
    in2[1] = 32'd2;
    in1[3] = 32'h0001_0000;
    in2[3] = 32'h0001_0000;
    req    = 4'b0010;
    #1;
    n_tests++;
    if (gnt !== 4'b0010) begin
      n_fail++; $display("FAIL trunc_gnt1: got %b expected 0010", gnt);
    end
    next_cycle();
    req = 4'b1000;
    #1;
    n_tests++;
    if (gnt !== 4'b1000) begin
      n_fail++; $display("FAIL trunc_gnt3: got %b expected 1000", gnt);
    end
    next_cycle();
    req = '0;
    n_tests++;
    if (rsp_valid !== 4'b0010 || rsp_data !== 32'hFFFF_FFFE) begin
      n_fail++; $display("FAIL trunc_ff: rsp_valid %b data %h expected 0010 fffffffe", rsp_valid, rsp_data);
    end
    next_cycle();
    n_tests++;
    if (rsp_valid !== 4'b1000 || rsp_data !== 32'h0000_0000) begin
      n_fail++; $display("FAIL trunc_wrap: rsp_valid %b data %h expected 1000 00000000", rsp_valid, rsp_data);
    end
    next_cycle();
  endtask

  task automatic test_midflight_reset();
    do_reset();
    in1[0] = 32'd9; in2[0] = 32'd9;
    in1[1] = 32'd3; in2[1] = 32'd4;
    in1[2] = 32'd5; in2[2] = 32'd6;
    req = 4'b0010;
    #1;
    n_tests++;
    if (gnt !== 4'b0010) begin
      n_fail++; $display("FAIL mid_gnt1: got %b expected 0010", gnt);
    end
    next_cycle();
    req = 4'b0100;
    #1;
    n_tests++;
    if (gnt !== 4'b0100) begin
      n_fail++; $display("FAIL mid_gnt2: got %b expected 0100", gnt);
    end
    next_cycle();
    rstn = 1'b0;
    req  = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_tests++;
      if (gnt !== 4'b0000 || rsp_valid !== 4'b0000) begin
        n_fail++; $display("FAIL mid_in_reset c%0d: gnt %b rsp_valid %b expected 0000 0000", c, gnt, rsp_valid);
      end
      next_cycle();
    end
    rstn = 1'b1;
    #1;
    n_tests++;
    if (gnt !== 4'b0001 || rsp_valid !== 4'b0000) begin
      n_fail++; $display("FAIL mid_restart: gnt %b rsp_valid %b expected 0001 0000", gnt, rsp_valid);
    end
    next_cycle();
    req = '0;
    #1;
    n_tests++;
    if (rsp_valid !== 4'b0000 || busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_after: rsp_valid %b busy %b expected 0000 1", rsp_valid, busy);
    end
    next_cycle();
    n_tests++;
    if (rsp_valid !== 4'b0001 || rsp_data !== 32'd81) begin
      n_fail++; $display("FAIL mid_fresh_rsp: rsp_valid %b data %0d expected 0001 81", rsp_valid, rsp_data);
    end
    next_cycle();
  endtask

  task automatic test_withdrawn();
    do_reset();
    in1[0] = 32'd11; in2[0] = 32'd2;
    in1[3] = 32'd13; in2[3] = 32'd3;
    req = 4'b1001;
    #1;
    n_tests++;
    if (gnt !== 4'b0001) begin
      n_fail++; $display("FAIL wd_gnt0: got %b expected 0001", gnt);
    end
    next_cycle();
    req = '0;
    for (int c = 1; c < 5; c++) begin
      logic [NUM_REQ-1:0] exp_rv;
      exp_rv = (c == 2) ? 4'b0001 : 4'b0000;
      #1;
      n_tests++;
      if (gnt !== 4'b0000 || rsp_valid !== exp_rv) begin
        n_fail++; $display("FAIL wd_c%0d: gnt %b rsp_valid %b expected 0000 %b", c, gnt, rsp_valid, exp_rv);
      end
      if (c == 2) begin
        n_tests++;
        if (rsp_data !== 32'd22) begin
          n_fail++; $display("FAIL wd_data: got %0d expected 22", rsp_data);
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rstn    = 1'b0;
    req     = '0;
    in1     = '0;
    in2     = '0;
    #1;
    test_reset();
    test_single();
    test_all_req();
    test_fairness();
    test_truncation();
    test_midflight_reset();
    test_withdrawn();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
